press_counter: RTL and testbench

PRESS_COUNTER -- requirements
Module: press_counter

---
 rtl/press_counter_pkg.sv | 32 +++
 rtl/press_counter_if.sv | 23 ++
 rtl/press_counter_btn_debounce.sv | 56 +++++
 rtl/press_counter.sv | 89 ++++++++
 tb/tb_press_counter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/press_counter_pkg.sv
// Shared display constants and count-operation helpers for the press counter
// and the seven-segment decoder that consumes its data output.
package press_counter_pkg;

    localparam int COUNT_W = 4;
    localparam int DATA_W  = COUNT_W + 1;

    // Code the seven-segment decoder interprets as "all segments off".
    localparam logic [DATA_W-1:0] BLANK_CODE = 5'b10000;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_CLR,
        OP_INC,
        OP_DEC
    } count_op_e;

    // Resolve same-cycle press pulses: clear wins, inc+dec cancel out.
    function automatic count_op_e decode_op(input logic inc, input logic dec,
                                            input logic clr);
        count_op_e op;
        op = OP_NONE;
        if (clr)
            op = OP_CLR;
        else if (inc && !dec)
            op = OP_INC;
        else if (dec && !inc)
            op = OP_DEC;
        return op;
    endfunction

endpackage

// File: rtl/press_counter_if.sv
// Button/blank inputs and display outputs of the press counter.
interface press_counter_if;

    logic                                 btn_inc;
    logic                                 btn_dec;
    logic                                 btn_clr;
    logic                                 blank;
    logic [press_counter_pkg::DATA_W-1:0] data;
    logic                                 overflow;

    // Stimulus side: drives buttons and blank, observes the display.
    modport master (
        output btn_inc, btn_dec, btn_clr, blank,
        input  data, overflow
    );

    // Counter side.
    modport slave (
        input  btn_inc, btn_dec, btn_clr, blank,
        output data, overflow
    );

endinterface

// File: rtl/press_counter_btn_debounce.sv
// Raw button -> synchronized -> debounced level -> single-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] stable_cnt;

    // Two-flop synchronizer for the asynchronous button input.
    // NOTE: non-blocking assignments make both flops sample the old values on
    // the same edge; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_q <= 2'b00;
        else
            sync_q <= {sync_q[0], btn_raw};
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES clocks;
    // any return to the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_q[1] == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            level      <= sync_q[1];
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level_d <= 1'b0;
        else
            level_d <= level;
    end

    // One pulse per accepted press; release and hold produce nothing.
    assign press = level & ~level_d;

endmodule

// File: rtl/press_counter.sv
// Up/down/clear press counter with bound handling and a registered display
// output. Raw buttons are cleaned up by one btn_debounce instance each.
module press_counter
    import press_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_COUNT       = 15,
    parameter bit WRAP            = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    press_counter_if.slave  bus
);

    localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

    logic               inc_press;
    logic               dec_press;
    logic               clr_press;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;
    logic               bound_hit;
    logic               bound_hit_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_inc), .press(inc_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_dec), .press(dec_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_clr), .press(clr_press)
    );

    // Next count from the prioritised press pulses, saturating or wrapping at
    // the bounds and flagging every bound hit.
    // NOTE: defaults assigned first so every path drives every output and no
    // latch is inferred.
    always_comb begin
        count_next = count;
        bound_hit  = 1'b0;
        unique case (decode_op(inc_press, dec_press, clr_press))
            OP_CLR: count_next = '0;
            OP_INC: begin
                if (count >= MAX_C) begin
                    bound_hit  = 1'b1;
                    count_next = WRAP ? '0 : MAX_C;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            OP_DEC: begin
                if (count == '0) begin
                    bound_hit  = 1'b1;
                    count_next = WRAP ? MAX_C : '0;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Count register; the bound flag is held one cycle so overflow lines up
    // with the registered data it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            bound_hit_q <= 1'b0;
        end else begin
            count       <= count_next;
            bound_hit_q <= bound_hit;
        end
    end

    // Registered display output; blanking hides the count without touching it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data     <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.data     <= bus.blank ? BLANK_CODE : {1'b0, count};
            bus.overflow <= bound_hit_q;
        end
    end

endmodule

// File: tb/tb_press_counter.sv
// Directed bench for press_counter with DEBOUNCE_CYCLES=4: a saturating and a
// wrapping instance share every input.
module tb_press_counter;

    localparam int DB  = 4;
    localparam int LAT = DB + 4;

    logic clk;
    logic rst_n;
    logic inc, dec, clr, blank;

    int total;
    int bad;
    int ovf_cnt0;
    int ovf_cnt1;

    press_counter_if bus0 ();
    press_counter_if bus1 ();

    assign bus0.btn_inc = inc;
    assign bus0.btn_dec = dec;
    assign bus0.btn_clr = clr;
    assign bus0.blank   = blank;
    assign bus1.btn_inc = inc;
    assign bus1.btn_dec = dec;
    assign bus1.btn_clr = clr;
    assign bus1.blank   = blank;

    press_counter #(.DEBOUNCE_CYCLES(DB), .MAX_COUNT(15), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    press_counter #(.DEBOUNCE_CYCLES(DB), .MAX_COUNT(15), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overflow pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus0.overflow === 1'b1) ovf_cnt0++;
        if (bus1.overflow === 1'b1) ovf_cnt1++;
    end

    typedef struct {
        logic       inc;
        logic       dec;
        logic       clr;
        logic [4:0] exp_sat;
        logic [4:0] exp_wrap;
        int         ovf_sat;
        int         ovf_wrap;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inc = 1'b0; dec = 1'b0; clr = 1'b0; blank = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    // One clean press of the selected buttons: hold long enough to register,
    // release, and let the release settle.
    task automatic press(input logic i, input logic d, input logic c);
        tick();
        ovf_cnt0 = 0;
        ovf_cnt1 = 0;
        inc = i; dec = d; clr = c;
        repeat (12) tick();
        inc = 1'b0; dec = 1'b0; clr = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ovf_cnt0 = 0;
        ovf_cnt1 = 0;

        //                inc dec clr sat wrap osat owrap
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd1, 5'd1,  0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 5'd2, 5'd2,  0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd1, 5'd1,  0, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd0,  0, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd15, 1, 1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 5'd1, 5'd0,  0, 1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd1, 5'd0,  0, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 5'd0, 5'd0,  0, 0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 5'd1, 5'd1,  0, 0};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 5'd0, 5'd0,  0, 0};

        // Reset state
        rst_n = 1'b0;
        inc = 1'b0; dec = 1'b0; clr = 1'b0; blank = 1'b0;
        #2;
        check("reset_data", bus0.data, 0);
        check("reset_ovf", bus0.overflow, 0);
        do_reset();
        check("post_reset_data", bus0.data, 0);
        check("post_reset_data_wrap", bus1.data, 0);

        // Single press latency: data changes exactly LAT clocks after the edge
        ovf_cnt0 = 0;
        inc = 1'b1;
        repeat (LAT - 1) tick();
        check("lat_before", bus0.data, 0);
        tick();
        check("lat_at", bus0.data, 1);
        repeat (20 - LAT) tick();
        inc = 1'b0;
        repeat (12) tick();
        check("lat_single_inc", bus0.data, 1);
        check("lat_no_ovf", ovf_cnt0, 0);

        // Bounce: 1,0,1,0 then hold high -> one increment, LAT after last rise
        inc = 1'b1; tick();
        inc = 1'b0; tick();
        inc = 1'b1; tick();
        inc = 1'b0; tick();
        inc = 1'b1;
        repeat (LAT - 1) tick();
        check("bounce_before", bus0.data, 1);
        tick();
        check("bounce_at", bus0.data, 2);
        repeat (12) tick();
        inc = 1'b0;
        repeat (12) tick();
        check("bounce_once", bus0.data, 2);

        // Table of single presses from count 0
        do_reset();
        for (int k = 0; k < 10; k++) begin
            press(vecs[k].inc, vecs[k].dec, vecs[k].clr);
            check($sformatf("vec%0d_data_sat", k), bus0.data, vecs[k].exp_sat);
            check($sformatf("vec%0d_data_wrap", k), bus1.data, vecs[k].exp_wrap);
            check($sformatf("vec%0d_ovf_sat", k), ovf_cnt0, vecs[k].ovf_sat);
            check($sformatf("vec%0d_ovf_wrap", k), ovf_cnt1, vecs[k].ovf_wrap);
        end

        // inc+dec together at count 7 leaves the count alone
        for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 1'b0);
        check("at_seven", bus0.data, 7);
        press(1'b1, 1'b1, 1'b0);
        check("inc_dec_hold", bus0.data, 7);
        check("inc_dec_no_ovf", ovf_cnt0, 0);

        // Blank at count 9, press during blank, release
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("at_nine", bus0.data, 9);
        blank = 1'b1;
        tick();
        check("blank_code", bus0.data, 5'b10000);
        press(1'b1, 1'b0, 1'b0);
        check("blank_during_press", bus0.data, 5'b10000);
        blank = 1'b0;
        tick();
        check("unblank_ten", bus0.data, 10);

        // Saturation / wrap: 16 presses from 0
        do_reset();
        for (int k = 0; k < 15; k++) press(1'b1, 1'b0, 1'b0);
        check("sat15_sat", bus0.data, 15);
        check("sat15_wrap", bus1.data, 15);
        tick();
        ovf_cnt0 = 0;
        ovf_cnt1 = 0;
        inc = 1'b1;
        repeat (LAT - 1) tick();
        check("ovf_early_sat", bus0.overflow, 0);
        check("ovf_early_wrap", bus1.overflow, 0);
        tick();
        check("ovf_sat_pulse", bus0.overflow, 1);
        check("ovf_wrap_pulse", bus1.overflow, 1);
        check("sat16_data", bus0.data, 15);
        check("wrap16_data", bus1.data, 0);
        tick();
        check("ovf_sat_end", bus0.overflow, 0);
        check("ovf_wrap_end", bus1.overflow, 0);
        repeat (10) tick();
        inc = 1'b0;
        repeat (12) tick();
        check("ovf_sat_once", ovf_cnt0, 1);
        check("ovf_wrap_once", ovf_cnt1, 1);
        check("sat_hold", bus0.data, 15);

        // Reset mid-debounce at count 5: async clear, no stale increment
        do_reset();
        for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 1'b0);
        check("at_five", bus0.data, 5);
        inc = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        inc = 1'b0;
        #1;
        check("async_clear", bus0.data, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("no_stale_inc", bus0.data, 0);

        // Button held through reset counts once, LAT after deassertion
        inc = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (LAT - 1) tick();
        check("held_before", bus0.data, 0);
        tick();
        check("held_at", bus0.data, 1);
        repeat (12) tick();
        inc = 1'b0;
        repeat (12) tick();
        check("held_once", bus0.data, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
